// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU control decode + execute with registered outputs.
// Optional ALU_EXEC_SHIFT_EN adds SLLV/SRLV; without it those functs decode as illegal.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        branch,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf,
    output logic [3:0]  alu_ctl,
    output logic        illegal,
    output logic        pc_src,
    output logic        out_valid
);
    localparam logic [3:0] CTL_AND  = 4'b0000;
    localparam logic [3:0] CTL_OR   = 4'b0001;
    localparam logic [3:0] CTL_ADD  = 4'b0010;
    localparam logic [3:0] CTL_SUB  = 4'b0110;
    localparam logic [3:0] CTL_SLT  = 4'b0111;
    localparam logic [3:0] CTL_SLLV = 4'b1000;
    localparam logic [3:0] CTL_SRLV = 4'b1001;
    localparam logic [3:0] CTL_NOR  = 4'b1100;
    localparam logic [3:0] CTL_ILL  = 4'b1111;

    logic [3:0]  ctl;
    logic [31:0] res, sum, diff;
    logic        ov;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q, ovf_d, ovf_q, illegal_d, illegal_q;
    logic        branch_d, branch_q, out_valid_d, out_valid_q;
    logic [3:0]  alu_ctl_d, alu_ctl_q;

    always_comb begin
        ctl = CTL_ILL;
        case (alu_op)
            2'b00: ctl = CTL_ADD;
            2'b01: ctl = CTL_SUB;
            2'b11: ctl = CTL_OR;
            default:
                case (funct)
                    6'b100000: ctl = CTL_ADD;
                    6'b100010: ctl = CTL_SUB;
                    6'b100100: ctl = CTL_AND;
                    6'b100101: ctl = CTL_OR;
                    6'b100111: ctl = CTL_NOR;
                    6'b101010: ctl = CTL_SLT;
`ifdef ALU_EXEC_SHIFT_EN
                    6'b000100: ctl = CTL_SLLV;
                    6'b000110: ctl = CTL_SRLV;
`endif
                    default:   ctl = CTL_ILL;
                endcase
        endcase
    end

    always_comb begin
        sum  = a + b;
        diff = a - b;
        res  = '0;
        ov   = 1'b0;
        case (ctl)
            CTL_AND: res = a & b;
            CTL_OR:  res = a | b;
            CTL_NOR: res = ~(a | b);
            CTL_ADD: begin
                res = sum;
                ov  = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            CTL_SUB: begin
                res = diff;
                ov  = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            // signed compare, so overflow of a-b cannot corrupt the answer
            CTL_SLT: res = {31'b0, $signed(a) < $signed(b)};
`ifdef ALU_EXEC_SHIFT_EN
            CTL_SLLV: res = b << a[4:0];
            CTL_SRLV: res = b >> a[4:0];
`endif
            default: res = '0;
        endcase
    end

    always_comb begin
        result_d    = in_valid ? res : result_q;
        zero_d      = in_valid ? (res == 32'b0) : zero_q;
        ovf_d       = in_valid ? ov : ovf_q;
        alu_ctl_d   = in_valid ? ctl : alu_ctl_q;
        illegal_d   = in_valid ? (ctl == CTL_ILL) : illegal_q;
        branch_d    = in_valid ? branch : branch_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            alu_ctl_q   <= '0;
            illegal_q   <= 1'b0;
            branch_q    <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            alu_ctl_q   <= alu_ctl_d;
            illegal_q   <= illegal_d;
            branch_q    <= branch_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign alu_ctl   = alu_ctl_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;
    assign pc_src    = branch_q & zero_q & ~illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for alu_exec_unit (both ALU_EXEC_SHIFT_EN builds).
module tb_alu_exec_unit;
    logic        clk, rst, in_valid, branch;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a, b, result;
    logic        zero, ovf, illegal, pc_src, out_valid;
    logic [3:0]  alu_ctl;

    alu_exec_unit dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .alu_op(alu_op), .funct(funct),
        .a(a), .b(b), .branch(branch), .result(result), .zero(zero), .ovf(ovf),
        .alu_ctl(alu_ctl), .illegal(illegal), .pc_src(pc_src), .out_valid(out_valid)
    );

    typedef struct {
        logic [31:0] res;
        logic        zero, ovf, ill, pc;
        logic [3:0]  ctl;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   n_cmp = 0, n_err = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [5:0] f,
                                   input logic [31:0] x, input logic [31:0] y, input logic br);
        exp_t   e;
        longint sx, sy, s;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        e.res = 0; e.ovf = 0; e.ill = 0; e.ctl = 4'b1111;
        if (op == 2'b10) begin
            case (f)
                6'h20: e.ctl = 4'b0010;
                6'h22: e.ctl = 4'b0110;
                6'h24: e.ctl = 4'b0000;
                6'h25: e.ctl = 4'b0001;
                6'h27: e.ctl = 4'b1100;
                6'h2A: e.ctl = 4'b0111;
`ifdef ALU_EXEC_SHIFT_EN
                6'h04: e.ctl = 4'b1000;
                6'h06: e.ctl = 4'b1001;
`endif
                default: e.ill = 1;
            endcase
        end else e.ctl = (op == 2'b00) ? 4'b0010 : (op == 2'b01) ? 4'b0110 : 4'b0001;
        case (e.ctl)
            4'b0010: begin s = sx + sy; e.res = x + y; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0110: begin s = sx - sy; e.res = x - y; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'b0000: e.res = x & y;
            4'b0001: e.res = x | y;
            4'b1100: e.res = ~(x | y);
            4'b0111: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'b1000: e.res = y << x[4:0];
            4'b1001: e.res = y >> x[4:0];
            default: e.res = 0;
        endcase
        e.zero = (e.res == 0);
        e.pc   = br && e.zero && !e.ill;
        return e;
    endfunction

    task automatic check_out(input string tag);
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, ".vld"}, {31'b0, out_valid}, 1);
            last = e;
        end else begin
            e = last;
            chk({tag, ".vld"}, {31'b0, out_valid}, 0);
        end
        chk({tag, ".res"}, result, e.res);
        chk({tag, ".zero"}, {31'b0, zero}, {31'b0, e.zero});
        chk({tag, ".ovf"}, {31'b0, ovf}, {31'b0, e.ovf});
        chk({tag, ".ctl"}, {28'b0, alu_ctl}, {28'b0, e.ctl});
        chk({tag, ".ill"}, {31'b0, illegal}, {31'b0, e.ill});
        chk({tag, ".pc"}, {31'b0, pc_src}, {31'b0, e.pc});
    endtask

    task automatic step(input string tag, input logic v, input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y, input logic br);
        in_valid = v; alu_op = op; funct = f; a = x; b = y; branch = br;
        if (v) q.push_back(model(op, f, x, y, br));
        @(posedge clk); #1;
        check_out(tag);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".res"}, result, 0);
        chk({tag, ".flags"}, {26'b0, zero, ovf, illegal, pc_src, out_valid, 1'b0}, 0);
        chk({tag, ".ctl"}, {28'b0, alu_ctl}, 0);
    endtask

    logic [5:0] fl [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h04, 6'h06, 6'h3F};

    initial begin
        last = '{res: 0, zero: 0, ovf: 0, ill: 0, pc: 0, ctl: 0};
        rst = 0; in_valid = 0; alu_op = 0; funct = 0; a = 0; b = 0; branch = 0;
        #1 chk_reset("rst0");
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1;
        step("idle", 0, 0, 0, 0, 0, 0);
        step("add", 1, 2'b00, 0, 5, 7, 0);
        step("addovf", 1, 2'b00, 0, 32'h7FFFFFFF, 1, 0);
        step("beq", 1, 2'b01, 0, 32'h1234, 32'h1234, 1);
        step("bne", 1, 2'b01, 0, 3, 4, 1);
        step("and", 1, 2'b10, 6'h24, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
        step("or", 1, 2'b10, 6'h25, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
        step("nor", 1, 2'b10, 6'h27, 32'hF0F0F0F0, 32'h0FF00FF0, 0);
        step("slt", 1, 2'b10, 6'h2A, 32'hFFFFFFFF, 1, 0);
        step("sltovf", 1, 2'b10, 6'h2A, 32'h80000000, 1, 0);
        step("subovf", 1, 2'b10, 6'h22, 32'h80000000, 1, 0);
        step("raddovf", 1, 2'b10, 6'h20, 32'h80000000, 32'h80000000, 1);
        step("ori", 1, 2'b11, 0, 32'h00FF0000, 32'h0000FF00, 0);
        step("ill", 1, 2'b10, 6'h3F, 9, 9, 1);
        step("hold1", 0, 2'b00, 0, 1, 2, 0);
        step("hold2", 0, 2'b01, 0, 7, 7, 1);
        step("sllv", 1, 2'b10, 6'h04, 4, 1, 0);
        step("srlv", 1, 2'b10, 6'h06, 4, 32'h80000100, 0);
        for (int i = 0; i < 40; i++)
            step("rnd", ($urandom_range(0, 4) != 0), 2'($urandom), fl[$urandom_range(0, 8)],
                 (i % 5 == 0) ? 32'h1234 : $urandom, (i % 5 == 0) ? 32'h1234 : $urandom, 1'($urandom));
        // asynchronous reset mid-cycle with a sample in flight
        in_valid = 1; alu_op = 2'b00; a = 1; b = 2; branch = 0;
        #3 rst = 0;
        #1 chk_reset("arst");
        q.delete();
        last = '{res: 0, zero: 0, ovf: 0, ill: 0, pc: 0, ctl: 0};
        @(posedge clk); #1 chk_reset("arst_edge");
        rst = 1; in_valid = 0;
        step("post_rst", 0, 0, 0, 0, 0, 0);
        step("post_add", 1, 2'b00, 0, 32'hFFFFFFFF, 1, 1);
        step("post_idle", 0, 0, 0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
